// File: rtl/acorn128_pkg.sv
// Shared state codes, message-bit source codes and step counts for the ACORN-128 sequencer.
package acorn128_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_AD      = 3'd2,
        ST_AD_PAD  = 3'd3,
        ST_ENC     = 3'd4,
        ST_ENC_PAD = 3'd5,
        ST_FINAL   = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        MB_ZERO    = 3'd0,
        MB_ONE     = 3'd1,
        MB_KEY     = 3'd2,
        MB_IV      = 3'd3,
        MB_DATA    = 3'd4,
        MB_KEY_INV = 3'd5
    } mbit_e;

    localparam int unsigned INIT_STEPS  = 1792;
    localparam int unsigned PAD_STEPS   = 256;
    localparam int unsigned FINAL_STEPS = 768;
    localparam int unsigned KEY_BITS    = 128;
    localparam int unsigned TAG_BITS    = 128;

endpackage

// File: rtl/acorn128_phase_ctrl_if.sv
// Command, data-pacing and per-step control bundle between a host (master) and the sequencer (slave).
// abort exists only when ACORN_ABORT_EN is defined.
interface acorn128_phase_ctrl_if #(
    parameter int unsigned LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] ad_len;
    logic [LEN_W-1:0] msg_len;
    logic             data_valid;
    logic             data_ready;
    logic             step_en;
    logic             ca;
    logic             cb;
    logic [2:0]       mbit_sel;
    logic [6:0]       kv_idx;
    logic             ks_valid;
    logic             tag_en;
    logic [2:0]       phase;
    logic             busy;
    logic             done;
`ifdef ACORN_ABORT_EN
    logic             abort;
`endif

    modport master (
`ifdef ACORN_ABORT_EN
        output abort,
`endif
        output start, ad_len, msg_len, data_valid,
        input  data_ready, step_en, ca, cb, mbit_sel, kv_idx, ks_valid, tag_en, phase, busy, done
    );

    modport slave (
`ifdef ACORN_ABORT_EN
        input  abort,
`endif
        input  start, ad_len, msg_len, data_valid,
        output data_ready, step_en, ca, cb, mbit_sel, kv_idx, ks_valid, tag_en, phase, busy, done
    );
endinterface

// File: rtl/acorn128_step_cnt.sv
// Per-phase step counter: clears on phase entry, counts enabled steps, flags the phase's last step.
// Zero latency on tc_o (combinational compare against the registered count).
module acorn128_step_cnt #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);
endmodule

// File: rtl/acorn128_phase_ctrl.sv
// ACORN-128 step sequencer INIT->AD->AD_PAD->ENC->ENC_PAD->FINAL->DONE; ACORN_ABORT_EN adds abort.
// One step per cycle except AD/ENC, which stall on data_valid=0; done at 1+1792+ad+256+msg+256+768.
module acorn128_phase_ctrl
#(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned INIT_STEPS  = acorn128_pkg::INIT_STEPS,
    parameter int unsigned PAD_STEPS   = acorn128_pkg::PAD_STEPS,
    parameter int unsigned FINAL_STEPS = acorn128_pkg::FINAL_STEPS
) (
    input  logic                  clk,
    input  logic                  rst,
    acorn128_phase_ctrl_if.slave  bus
);
    import acorn128_pkg::*;

    // Wide enough for both the 1792-step INIT phase and a full-range length.
    localparam int unsigned CNT_W = (LEN_W > 12) ? LEN_W : 12;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] ad_len_q, msg_len_q;
    logic [CNT_W-1:0] cnt, last;
    logic             tc, clr;
    logic             step_en, ca, cb, rdy, ks, tag, done_p;
    mbit_e            mbit;
    logic [6:0]       kv;
    logic             abort_w;

`ifdef ACORN_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step_en = 1'b0;
        ca      = 1'b0;
        cb      = 1'b0;
        rdy     = 1'b0;
        ks      = 1'b0;
        tag     = 1'b0;
        done_p  = 1'b0;
        mbit    = MB_ZERO;
        kv      = 7'd0;
        last    = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_INIT;
            end
            ST_INIT: begin
                step_en = 1'b1;
                ca      = 1'b1;
                cb      = 1'b1;
                // Key restarts at bit 0 every 128 steps past 256, so the low bits are the index throughout.
                kv      = cnt[6:0];
                if (cnt < CNT_W'(KEY_BITS))           mbit = MB_KEY;
                else if (cnt < CNT_W'(2 * KEY_BITS))  mbit = MB_IV;
                else if (cnt == CNT_W'(2 * KEY_BITS)) mbit = MB_KEY_INV;
                else                                  mbit = MB_KEY;
                last = CNT_W'(INIT_STEPS - 1);
                if (tc) state_d = (ad_len_q == '0) ? ST_AD_PAD : ST_AD;
            end
            ST_AD: begin
                rdy     = 1'b1;
                step_en = bus.data_valid;
                mbit    = MB_DATA;
                ca      = 1'b1;
                cb      = 1'b1;
                last    = CNT_W'(ad_len_q) - CNT_W'(1);
                if (step_en && tc) state_d = ST_AD_PAD;
            end
            ST_AD_PAD, ST_ENC_PAD: begin
                step_en = 1'b1;
                mbit    = (cnt == '0) ? MB_ONE : MB_ZERO;
                ca      = (cnt < CNT_W'(KEY_BITS));
                cb      = (state_q == ST_AD_PAD);
                last    = CNT_W'(PAD_STEPS - 1);
                if (tc) begin
                    if (state_q == ST_ENC_PAD)  state_d = ST_FINAL;
                    else if (msg_len_q == '0)   state_d = ST_ENC_PAD;
                    else                        state_d = ST_ENC;
                end
            end
            ST_ENC: begin
                rdy     = 1'b1;
                step_en = bus.data_valid;
                mbit    = MB_DATA;
                ca      = 1'b1;
                ks      = bus.data_valid;
                last    = CNT_W'(msg_len_q) - CNT_W'(1);
                if (step_en && tc) state_d = ST_ENC_PAD;
            end
            ST_FINAL: begin
                step_en = 1'b1;
                ca      = 1'b1;
                cb      = 1'b1;
                tag     = (cnt >= CNT_W'(FINAL_STEPS - TAG_BITS));
                last    = CNT_W'(FINAL_STEPS - 1);
                if (tc) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_p  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_w && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            step_en = 1'b0;
            rdy     = 1'b0;
            tag     = 1'b0;
            ks      = 1'b0;
            done_p  = 1'b0;
        end
    end

    assign clr = (state_d != state_q);

    acorn128_step_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .en_i   (step_en),
        .last_i (last),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ad_len_q  <= '0;
            msg_len_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.start) begin
                ad_len_q  <= bus.ad_len;
                msg_len_q <= bus.msg_len;
            end
        end
    end

    assign bus.step_en    = step_en;
    assign bus.ca         = ca;
    assign bus.cb         = cb;
    assign bus.data_ready = rdy;
    assign bus.ks_valid   = ks;
    assign bus.tag_en     = tag;
    assign bus.done       = done_p;
    assign bus.mbit_sel   = mbit;
    assign bus.kv_idx     = kv;
    assign bus.phase      = state_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_acorn128_phase_ctrl.sv
// Directed bench for acorn128_phase_ctrl: per-cycle expected outputs queued from the protocol, popped and compared.
module tb_acorn128_phase_ctrl;
    import acorn128_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    acorn128_phase_ctrl_if #(.LEN_W(16)) bus ();
    acorn128_phase_ctrl #(.LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [2:0] phase;
        logic       busy, done, step_en, ca, cb;
        logic [2:0] mbit;
        logic [6:0] kv;
        logic       ks, tag, rdy;
    } obs_t;

    typedef struct {
        logic st, dv, ab;
        obs_t exp;
    } ent_t;

    ent_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   done_idx, tag_cnt, ks_cnt, ad_steps, enc_steps, exp_done_idx;

    function automatic obs_t mk(logic [2:0] ph, logic bz, logic dn, logic se, logic a, logic b,
                                logic [2:0] mb, logic [6:0] kv, logic k, logic tg, logic rd);
        obs_t o;
        o.phase = ph; o.busy = bz; o.done = dn; o.step_en = se; o.ca = a; o.cb = b;
        o.mbit = mb; o.kv = kv; o.ks = k; o.tag = tg; o.rdy = rd;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.phase, bus.busy, bus.done, bus.step_en, bus.ca, bus.cb,
                  bus.mbit_sel, bus.kv_idx, bus.ks_valid, bus.tag_en, bus.data_ready);
    endfunction

    function automatic obs_t idle_o();
        return mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MB_ZERO, 7'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(logic st, logic dv, logic ab, obs_t e);
        ent_t x;
        x.st = st; x.dv = dv; x.ab = ab; x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected trace of one operation; abort_enc>=0 aborts on that ENC bit.
    task automatic build(int ad, int msg, bit toggle, int start_in_final, int abort_enc);
        logic [2:0] mb;
        logic       dv;
        int         k, c, kvi;
        exp_done_idx = -1;
        push(1'b1, 1'b0, 1'b0, idle_o());
        for (int n = 0; n < 1792; n++) begin
            if (n < 128)       begin mb = MB_KEY;     kvi = n;             end
            else if (n < 256)  begin mb = MB_IV;      kvi = n - 128;       end
            else if (n == 256) begin mb = MB_KEY_INV; kvi = 0;             end
            else               begin mb = MB_KEY;     kvi = (n - 256) % 128; end
            push(1'b0, rbit(), 1'b0, mk(ST_INIT, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, mb, 7'(kvi), 1'b0, 1'b0, 1'b0));
        end
        k = 0; c = 0;
        while (k < ad) begin
            dv = toggle ? ((c % 2) == 0) : 1'b1;
            push(1'b0, dv, 1'b0, mk(ST_AD, 1'b1, 1'b0, dv, 1'b1, 1'b1, MB_DATA, 7'd0, 1'b0, 1'b0, 1'b1));
            if (dv) k++;
            c++;
        end
        for (int n = 0; n < 256; n++)
            push(1'b0, rbit(), 1'b0, mk(ST_AD_PAD, 1'b1, 1'b0, 1'b1, n < 128, 1'b1,
                 (n == 0) ? MB_ONE : MB_ZERO, 7'd0, 1'b0, 1'b0, 1'b0));
        k = 0; c = 0;
        while (k < msg) begin
            dv = toggle ? ((c % 2) == 0) : 1'b1;
            if (k == abort_enc && dv) begin
                push(1'b0, dv, 1'b1, mk(ST_ENC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MB_DATA, 7'd0, 1'b0, 1'b0, 1'b0));
                push(1'b0, 1'b0, 1'b0, idle_o());
                push(1'b0, 1'b0, 1'b0, idle_o());
                return;
            end
            push(1'b0, dv, 1'b0, mk(ST_ENC, 1'b1, 1'b0, dv, 1'b1, 1'b0, MB_DATA, 7'd0, dv, 1'b0, 1'b1));
            if (dv) k++;
            c++;
        end
        for (int n = 0; n < 256; n++)
            push(1'b0, rbit(), 1'b0, mk(ST_ENC_PAD, 1'b1, 1'b0, 1'b1, n < 128, 1'b0,
                 (n == 0) ? MB_ONE : MB_ZERO, 7'd0, 1'b0, 1'b0, 1'b0));
        for (int n = 0; n < 768; n++)
            push(n == start_in_final, rbit(), 1'b0, mk(ST_FINAL, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                 MB_ZERO, 7'd0, 1'b0, n >= 640, 1'b0));
        exp_done_idx = sbq.size();
        push(1'b0, rbit(), 1'b0, mk(ST_DONE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MB_ZERO, 7'd0, 1'b0, 1'b0, 1'b0));
        push(1'b0, 1'b0, 1'b0, idle_o());
        push(1'b0, 1'b0, 1'b0, idle_o());
    endtask

    task automatic run_queue(string tag, int maxn);
        ent_t x;
        obs_t o;
        int   idx;
        idx = 0;
        done_idx = -1; tag_cnt = 0; ks_cnt = 0; ad_steps = 0; enc_steps = 0;
        while (sbq.size() > 0 && idx < maxn) begin
            x = sbq.pop_front();
            @(negedge clk);
            bus.start      = x.st;
            bus.data_valid = x.dv;
`ifdef ACORN_ABORT_EN
            bus.abort      = x.ab;
`endif
            #1;
            o = sample();
            if (o.done === 1'b1 && done_idx < 0) done_idx = idx;
            if (o.tag === 1'b1) tag_cnt++;
            if (o.ks === 1'b1) ks_cnt++;
            if (o.step_en === 1'b1 && o.phase === ST_AD) ad_steps++;
            if (o.step_en === 1'b1 && o.phase === ST_ENC) enc_steps++;
            total++;
            assert (o === x.exp) else begin
                bad++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, idx, o, x.exp);
            end
            idx++;
        end
        sbq.delete();
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
`ifdef ACORN_ABORT_EN
        bus.abort      = 1'b0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        bus.start = 1'b0; bus.ad_len = '0; bus.msg_len = '0; bus.data_valid = 1'b1;
`ifdef ACORN_ABORT_EN
        bus.abort = 1'b0;
`endif
        #12;
        o = sample();
        total++;
        assert (o === idle_o()) else begin
            bad++;
            $error("FAIL reset_state observed=%h expected=%h", o, idle_o());
        end
        @(negedge clk);
        bus.data_valid = 1'b0;
        rst = 1'b1;

        // Empty AD and message, start pulsed during FINAL must be ignored.
        bus.ad_len = 16'd0; bus.msg_len = 16'd0;
        build(0, 0, 1'b0, 100, -1);
        run_queue("t1_trace", 100000);
        chk("t1_done_latency", done_idx, 3073);
        chk("t1_tag_count", tag_cnt, 128);
        chk("t1_ks_count", ks_cnt, 0);

        // Short AD and message with 1010 valid pacing.
        bus.ad_len = 16'd8; bus.msg_len = 16'd16;
        build(8, 16, 1'b1, -1, -1);
        bus.ad_len = 16'd3;
        bus.ad_len = 16'd8;
        run_queue("t2_trace", 100000);
        chk("t2_ad_steps", ad_steps, 8);
        chk("t2_enc_steps", enc_steps, 16);
        chk("t2_ks_count", ks_cnt, 16);
        chk("t2_done_latency", done_idx, 3119);
        chk("t2_tag_count", tag_cnt, 128);

        // Asynchronous reset in the middle of INIT step 500.
        bus.ad_len = 16'd5; bus.msg_len = 16'd7;
        build(5, 7, 1'b0, -1, -1);
        run_queue("t3_init", 502);
        #1 rst = 1'b0;
        #1 o = sample();
        total++;
        assert (o === idle_o()) else begin
            bad++;
            $error("FAIL t3_async_reset observed=%h expected=%h", o, idle_o());
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 o = sample();
            total++;
            assert (o === idle_o()) else begin
                bad++;
                $error("FAIL t3_idle_after_reset cyc=%0d observed=%h expected=%h", i, o, idle_o());
            end
        end

        // Fresh operation after the reset.
        bus.ad_len = 16'd3; bus.msg_len = 16'd5;
        build(3, 5, 1'b0, -1, -1);
        run_queue("t4_trace", 100000);
        chk("t4_done_latency", done_idx, 3081);
        chk("t4_ks_count", ks_cnt, 5);

`ifdef ACORN_ABORT_EN
        bus.ad_len = 16'd2; bus.msg_len = 16'd6;
        build(2, 6, 1'b0, -1, 3);
        run_queue("t5_abort", 100000);
        chk("t5_no_done", done_idx, -1);
        chk("t5_enc_steps", enc_steps, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
